pts_step_sequencer: RTL
=======================

Name: pts_step_sequencer

Overview:
Autonomous step sequencer for the 32-channel pulse/TTL sequence path. It owns a DEPTH-entry table of {output code, dwell time}. On start it replays the table onto oCode, advancing either on a per-step dwell timer or on external trigger edges. It replaces host-driven index stepping with deterministic, clock-accurate step timing.

Parameters:
DEPTH, 256, number of table entries
AW, 8, index/address width (log2 DEPTH)
DW, 32, output code width (one bit per channel)
TW, 24, dwell counter width in iClk cycles

Ports:
iClk  in  1  single system clock; all logic on rising edge
iRst  in  1  synchronous, active-high reset
iWR_EN  in  1  table write strobe; accepted only when oBusy=0
iWR_ADDR  in  AW  table write address
iWR_CODE  in  DW  code for the entry
iWR_DWELL  in  TW  dwell for the entry, in cycles; 0 is treated as 1
iSTART  in  1  start pulse
iSTOP  in  1  abort pulse
iLAST  in  AW  index of the final step; latched at start
iLOOP  in  1  1 = wrap from iLAST back to step 0; latched at start
iEXT_TRIG_MODE  in  1  1 = advance on iTrigger rising edge and ignore dwell; latched at start
iTrigger  in  1  external trigger, already synchronous to iClk
oCode  out  DW  current step code
oIndex  out  AW  current step index
oBusy  out  1  sequence active
oStepStrobe  out  1  one-cycle pulse, first cycle of each step
oDone  out  1  one-cycle pulse on normal (non-loop) completion

Behaviour:
- Reset values: oCode=0, oIndex=0, oBusy=0, oStepStrobe=0, oDone=0, state IDLE, dwell counter 0, trigger edge register 0. Table contents are not cleared.
- Table is synchronous-read memory with 1-cycle read latency. A write in cycle t is visible to a read issued at cycle t+1 or later. iWR_EN while oBusy=1 is ignored.
- States: IDLE, PREFETCH, RUN.
- IDLE: on iSTART=1 and iSTOP=0, latch iLAST, iLOOP and iEXT_TRIG_MODE, issue a read of address 0, and go to PREFETCH. oBusy=1 from the next cycle.
- PREFETCH (1 cycle): load entry 0 into oCode and the dwell counter, set oIndex=0, pulse oStepStrobe, and issue a prefetch read of the next index. Go to RUN.
- Start latency: iSTART sampled at edge t gives oCode=code[0] and oStepStrobe=1 in cycle t+2.
- Next index: index+1. At latched iLAST it is 0 if iLOOP=1; otherwise there is none. Index arithmetic wraps modulo 2^AW.
- RUN, timer mode: step k holds oCode for exactly max(D_k,1) cycles. On its final cycle, the next step loads on the following edge using the prefetched entry, pulses oStepStrobe, and issues a new prefetch. No gap cycles between steps.
- RUN, external mode:
  - Edge detection: edge = iTrigger & ~iTrigger_q.
  - An edge seen in cycle c loads the next step in cycle c+1.
  - Edges are ignored in IDLE and in PREFETCH.
  - iTrigger held high produces one advance only.
- End of step iLAST with latched iLOOP=0: the next cycle gives oBusy=0 and oDone=1 for one cycle, and state returns to IDLE. oCode and oIndex hold the last step's values.
- iSTOP in PREFETCH or RUN: IDLE next cycle, oBusy=0, no oDone. oCode and oIndex hold.
- iSTOP in IDLE: no effect.
- iSTART and iSTOP in the same cycle: iSTOP wins.
- iSTART while oBusy=1 is ignored.
- iLAST greater than DEPTH-1 (only possible when DEPTH<2^AW) is clamped to DEPTH-1.
- iRst asserted mid-run: all outputs return to reset values on that edge, with no oDone.
- oStepStrobe and oDone are never high in the same cycle.

Test Plan:
- Write entries 0..3 with codes 0x1,0x2,0x4,0x8 and dwells 3,1,0,5; iLAST=3, iLOOP=0, timer mode; iSTART at t -> oCode 0x1 during t+2..t+4, 0x2 at t+5, 0x4 at t+6, 0x8 during t+7..t+11; oDone=1 and oBusy=0 at t+12; oCode stays 0x8.
- Same table with iLOOP=1 -> after step 3, oCode=0x1 and oIndex=0 at t+12 with oStepStrobe=1; no oDone; the sequence repeats with period 10 cycles; iSTOP -> oBusy=0 next cycle, no oDone.
- External mode, iLAST=1, iTrigger high at c for 4 cycles, then high again at c+10 -> oIndex=1 at c+1 only; oDone at c+11.
- iWR_EN writing entry 1 with 0xFF while busy -> after the run completes, a rerun still shows the old entry-1 code.
- iSTART and iSTOP together in IDLE -> oBusy stays 0. iSTART while running -> no restart and the step timing is unchanged.
- iRst for 1 cycle mid-RUN -> next cycle oCode=0, oIndex=0, oBusy=0, no oDone; the table is retained, and a fresh iSTART replays entry 0.

Source files
------------

// File: rtl/pts_step_sequencer.sv
// Table-driven step sequencer: replays {code, dwell} entries onto oCode, advancing
// on a per-step dwell timer or on rising edges of an external trigger.
module pts_step_sequencer #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int TW    = 24
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iWR_EN,
    input  logic [AW-1:0] iWR_ADDR,
    input  logic [DW-1:0] iWR_CODE,
    input  logic [TW-1:0] iWR_DWELL,
    input  logic          iSTART,
    input  logic          iSTOP,
    input  logic [AW-1:0] iLAST,
    input  logic          iLOOP,
    input  logic          iEXT_TRIG_MODE,
    input  logic          iTrigger,
    output logic [DW-1:0] oCode,
    output logic [AW-1:0] oIndex,
    output logic          oBusy,
    output logic          oStepStrobe,
    output logic          oDone
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t state, state_n;

    logic [DW+TW-1:0] mem [DEPTH];
    logic [DW+TW-1:0] rd_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             wr_addr_ok;

    logic [AW-1:0] last_q;
    logic [AW-1:0] last_clamped;
    logic          loop_q;
    logic          ext_q;
    logic [TW-1:0] dwell_cnt;
    logic [TW-1:0] dwell_load;
    logic          trig_q;

    logic          trig_edge;
    logic          at_last;
    logic          step_end;
    logic          load_step;
    logic          finish;
    logic          latch_cfg;
    logic [AW-1:0] step_idx;

    // Range guards only exist when the table does not fill the address space.
    generate
        if (DEPTH < 2**AW) begin : g_partial
            localparam logic [AW-1:0] MAX_IDX = AW'(DEPTH - 1);
            assign last_clamped = (iLAST > MAX_IDX) ? MAX_IDX : iLAST;
            assign wr_addr_ok   = (iWR_ADDR <= MAX_IDX);
        end else begin : g_full
            assign last_clamped = iLAST;
            assign wr_addr_ok   = 1'b1;
        end
    endgenerate

    assign oBusy      = (state != IDLE);
    assign dwell_load = (rd_data[TW-1:0] == '0) ? TW'(1) : rd_data[TW-1:0];

    always_ff @(posedge iClk) begin
        if (iWR_EN && (state == IDLE) && wr_addr_ok) begin
            mem[iWR_ADDR] <= {iWR_CODE, iWR_DWELL};
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_comb begin
        state_n   = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        load_step = 1'b0;
        finish    = 1'b0;
        latch_cfg = 1'b0;
        step_idx  = '0;
        trig_edge = iTrigger & ~trig_q;
        at_last   = (oIndex == last_q);
        step_end  = ext_q ? trig_edge : (dwell_cnt == TW'(1));

        case (state)
            IDLE: begin
                if (iSTART && !iSTOP) begin
                    latch_cfg = 1'b1;
                    rd_en     = 1'b1;
                    state_n   = PREFETCH;
                end
            end
            PREFETCH: begin
                if (iSTOP) begin
                    state_n = IDLE;
                end else begin
                    load_step = 1'b1;
                    state_n   = RUN;
                end
            end
            RUN: begin
                if (iSTOP) begin
                    state_n = IDLE;
                end else if (step_end) begin
                    if (at_last && !loop_q) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        load_step = 1'b1;
                        step_idx  = at_last ? '0 : oIndex + AW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Every step load prefetches its successor so back-to-back steps need no gap.
        if (load_step) begin
            rd_en   = 1'b1;
            rd_addr = (step_idx == last_q) ? '0 : step_idx + AW'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state       <= IDLE;
            oCode       <= '0;
            oIndex      <= '0;
            oStepStrobe <= 1'b0;
            oDone       <= 1'b0;
            dwell_cnt   <= '0;
            trig_q      <= 1'b0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            state       <= state_n;
            trig_q      <= iTrigger;
            oStepStrobe <= load_step;
            oDone       <= finish;
            if (latch_cfg) begin
                last_q <= last_clamped;
                loop_q <= iLOOP;
                ext_q  <= iEXT_TRIG_MODE;
            end
            if (load_step) begin
                oCode     <= rd_data[DW+TW-1:TW];
                oIndex    <= step_idx;
                dwell_cnt <= dwell_load;
            end else if ((state == RUN) && (dwell_cnt > TW'(1))) begin
                dwell_cnt <= dwell_cnt - TW'(1);
            end
        end
    end

endmodule
